csr_trap_seq: RTL

//  Sequences machine-mode trap entry and MRET return through the single CLINT-side CSR port:

---
 rtl/csr_trap_seq.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/csr_trap_seq.sv
// Machine-mode trap entry / MRET return sequencer driving the CLINT-side CSR port.
// Steps mepc/mcause/mstatus writes through one port, then redirects the PC and acks.
module csr_trap_seq #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          trap_req_i,
  input  logic [DW-1:0] trap_pc_i,
  input  logic [DW-1:0] trap_cause_i,
  input  logic          mret_req_i,
  output logic          trap_ack_o,
  output logic          mret_ack_o,
  output logic          busy_o,
  output logic          redirect_o,
  output logic [DW-1:0] redirect_pc_o,
  input  logic [DW-1:0] csr_mtvec_i,
  input  logic [DW-1:0] csr_mepc_i,
  input  logic [DW-1:0] csr_rdata_i,
  output logic          csr_we_o,
  output logic [AW-1:0] csr_waddr_o,
  output logic [DW-1:0] csr_wdata_o,
  output logic [AW-1:0] csr_raddr_o,
  input  logic          ex_csr_we_i,
  input  logic [AW-1:0] ex_csr_waddr_i
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    IDLE, T_EPC, T_CAU, T_STA, T_RDR, M_RD, M_STA, M_RDR
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] pc_q, cause_q, st_q;
  logic [11:0]   waddr, raddr;
  logic          wr_state;
  logic          collide;
  logic [DW-1:0] tvec_base, tvec_off, trap_target;

  // Only the low 12 address bits select a CSR.
  logic unused_ex_addr_hi;
  assign unused_ex_addr_hi = ^ex_csr_waddr_i[AW-1:12];

  // Write/read address decode per state; shared by outputs and collision check.
  always_comb begin
    waddr    = '0;
    raddr    = '0;
    wr_state = 1'b0;
    unique case (state_q)
      T_EPC:         begin wr_state = 1'b1; waddr = ADDR_MEPC;    end
      T_CAU:         begin wr_state = 1'b1; waddr = ADDR_MCAUSE;  raddr = ADDR_MSTATUS; end
      T_STA, M_STA:  begin wr_state = 1'b1; waddr = ADDR_MSTATUS; end
      M_RD:          raddr = ADDR_MSTATUS;
      default:       ;
    endcase
  end

  // EX owns the port when it targets the same CSR; we hold and retry.
  assign collide = wr_state && ex_csr_we_i && (ex_csr_waddr_i[11:0] == waddr);

  // Trap target: vectored mode offsets interrupts by 4*cause, wrapping at DW bits.
  assign tvec_base   = {csr_mtvec_i[DW-1:2], 2'b00};
  assign tvec_off    = {cause_q[DW-3:0], 2'b00};
  assign trap_target = (csr_mtvec_i[1:0] == 2'b01 && cause_q[DW-1]) ? tvec_base + tvec_off
                                                                     : tvec_base;

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (trap_req_i) state_d = T_EPC;
             else if (mret_req_i) state_d = M_RD;
      T_EPC: if (!collide) state_d = T_CAU;
      T_CAU: if (!collide) state_d = T_STA;
      T_STA: if (!collide) state_d = T_RDR;
      T_RDR: state_d = IDLE;
      M_RD:  state_d = M_STA;
      M_STA: if (!collide) state_d = M_RDR;
      M_RDR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from state and captured operands.
  always_comb begin
    trap_ack_o    = 1'b0;
    mret_ack_o    = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = '0;
    csr_wdata_o   = '0;
    busy_o        = (state_q != IDLE);
    csr_we_o      = wr_state;
    csr_waddr_o   = AW'(waddr);
    csr_raddr_o   = AW'(raddr);
    unique case (state_q)
      T_EPC: csr_wdata_o = pc_q;
      T_CAU: csr_wdata_o = cause_q;
      T_STA: begin
        csr_wdata_o    = st_q;
        csr_wdata_o[7] = st_q[3];
        csr_wdata_o[3] = 1'b0;
      end
      T_RDR: begin
        redirect_o    = 1'b1;
        trap_ack_o    = 1'b1;
        redirect_pc_o = trap_target;
      end
      M_STA: begin
        csr_wdata_o    = st_q;
        csr_wdata_o[3] = st_q[7];
        csr_wdata_o[7] = 1'b1;
      end
      M_RDR: begin
        redirect_o    = 1'b1;
        mret_ack_o    = 1'b1;
        redirect_pc_o = csr_mepc_i;
      end
      default: ;
    endcase
  end

  // State register and operand capture; mstatus is re-sampled on every read-state cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && trap_req_i) begin
        pc_q    <= trap_pc_i;
        cause_q <= trap_cause_i;
      end
      if (state_q == T_CAU || state_q == M_RD)
        st_q <= csr_rdata_i;
    end
  end

endmodule
